// File: rtl/lsu_mem_ctrl.sv
// Load/store unit: turns an ALU effective address into a byte-lane-aware req/ack
// memory transaction, formats load data and reports misaligned/illegal/timeout errors.
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_lsu_req,
  input  logic        i_lsu_wren,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_lsu_addr,
  input  logic [31:0] i_st_data,
  output logic        o_lsu_busy,
  output logic        o_lsu_done,
  output logic [31:0] o_ld_data,
  output logic [1:0]  o_err_code,
  output logic        o_mem_req,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic [1:0]  o_dbg_state
);

  // Handshake: o_mem_req rises with addr/wdata/bmask/wren already valid and holds them
  // stable until an edge that samples i_mem_ack=1; that edge completes the access
  // (write accepted, or i_mem_rdata valid) and drops o_mem_req.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        wren_q, wren_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_wren_q, mem_wren_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_bmask_q, mem_bmask_d;
  logic [31:0] ld_data_q, ld_data_d;
  logic [1:0]  err_q, err_d;

  logic        req_illegal;
  logic        req_misaligned;
  logic [3:0]  req_bmask;
  logic [31:0] req_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_fmt;

  always_comb begin
    req_illegal    = 1'b0;
    req_misaligned = 1'b0;
    req_bmask      = 4'b1111;
    req_wdata      = i_st_data;
    case (i_funct3)
      3'b011, 3'b110, 3'b111: req_illegal = 1'b1;
      3'b100, 3'b101:         req_illegal = i_lsu_wren;
      default:                req_illegal = 1'b0;
    endcase
    case (i_funct3[1:0])
      2'b00: begin
        req_bmask = 4'b0001 << i_lsu_addr[1:0];
        req_wdata = {4{i_st_data[7:0]}};
      end
      2'b01: begin
        req_misaligned = i_lsu_addr[0];
        req_bmask      = i_lsu_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata      = {2{i_st_data[15:0]}};
      end
      default: begin
        req_misaligned = (i_lsu_addr[1:0] != 2'b00);
        req_bmask      = 4'b1111;
        req_wdata      = i_st_data;
      end
    endcase
  end

  // Load formatting uses the offset/width latched at request time.
  always_comb begin
    ld_byte = i_mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_fmt = {24'b0, ld_byte};
      3'b101:  ld_fmt = {16'b0, ld_half};
      default: ld_fmt = i_mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    funct3_d    = funct3_q;
    wren_d      = wren_q;
    mem_req_d   = mem_req_q;
    mem_wren_d  = mem_wren_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_bmask_d = mem_bmask_q;
    ld_data_d   = ld_data_q;
    err_d       = err_q;
    o_lsu_busy  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d      = 8'd0;
        o_lsu_busy = i_lsu_req;
        if (i_lsu_req) begin
          if (req_illegal || req_misaligned) begin
            err_d     = req_illegal ? 2'b11 : 2'b01;
            ld_data_d = 32'd0;
            state_d   = ST_DONE;
          end else begin
            off_d       = i_lsu_addr[1:0];
            funct3_d    = i_funct3;
            wren_d      = i_lsu_wren;
            mem_req_d   = 1'b1;
            mem_wren_d  = i_lsu_wren;
            mem_addr_d  = {i_lsu_addr[31:2], 2'b00};
            mem_wdata_d = req_wdata;
            mem_bmask_d = req_bmask;
            err_d       = 2'b00;
            state_d     = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        o_lsu_busy = 1'b1;
        if (i_mem_ack) begin
          mem_req_d = 1'b0;
          err_d     = 2'b00;
          if (!wren_q) ld_data_d = ld_fmt;
          state_d   = ST_DONE;
        end else if (cnt_q == LAST_CNT) begin
          mem_req_d = 1'b0;
          err_d     = 2'b10;
          ld_data_d = 32'd0;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      off_q       <= 2'd0;
      funct3_q    <= 3'd0;
      wren_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_wren_q  <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_bmask_q <= 4'd0;
      ld_data_q   <= 32'd0;
      err_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      funct3_q    <= funct3_d;
      wren_q      <= wren_d;
      mem_req_q   <= mem_req_d;
      mem_wren_q  <= mem_wren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_bmask_q <= mem_bmask_d;
      ld_data_q   <= ld_data_d;
      err_q       <= err_d;
    end
  end

  assign o_lsu_done  = (state_q == ST_DONE);
  assign o_ld_data   = ld_data_q;
  assign o_err_code  = err_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_wren  = mem_wren_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_bmask = mem_bmask_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed and random load/store transactions against an
// arithmetic reference model of lanes, extension, error codes and latency.
module tb_lsu_mem_ctrl;

  localparam int T = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_lsu_req;
  logic        i_lsu_wren;
  logic [2:0]  i_funct3;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_st_data;
  logic        o_lsu_busy;
  logic        o_lsu_done;
  logic [31:0] o_ld_data;
  logic [1:0]  o_err_code;
  logic        o_mem_req;
  logic        o_mem_wren;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_bmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic [1:0]  o_dbg_state;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_ld   = 32'd0;

  lsu_mem_ctrl #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_lsu_req   (i_lsu_req),
    .i_lsu_wren  (i_lsu_wren),
    .i_funct3    (i_funct3),
    .i_lsu_addr  (i_lsu_addr),
    .i_st_data   (i_st_data),
    .o_lsu_busy  (o_lsu_busy),
    .o_lsu_done  (o_lsu_done),
    .o_ld_data   (o_ld_data),
    .o_err_code  (o_err_code),
    .o_mem_req   (o_mem_req),
    .o_mem_wren  (o_mem_wren),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .o_mem_bmask (o_mem_bmask),
    .i_mem_ack   (i_mem_ack),
    .i_mem_rdata (i_mem_rdata),
    .o_dbg_state (o_dbg_state)
  );

  // clock / watchdog
  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  // Reference model: size in bytes, offset arithmetic, mask-based extension.
  task automatic model(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] st, input logic [31:0] rdata,
                       output logic [1:0] err, output logic [3:0] bm,
                       output logic [31:0] wd, output logic [31:0] ld);
    int sz;
    int o;
    logic [31:0] mask;
    logic [31:0] v;
    sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    o  = int'(addr % 32'd4);
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (wren && (f3 == 3'd4 || f3 == 3'd5)))
      err = 2'b11;
    else if (o % sz != 0)
      err = 2'b01;
    else
      err = 2'b00;
    bm   = 4'(((1 << sz) - 1) << o);
    wd   = (sz == 1) ? {24'b0, st[7:0]} * 32'h0101_0101 :
           (sz == 2) ? {16'b0, st[15:0]} * 32'h0001_0001 : st;
    mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 32'd1;
    v    = (rdata >> (8 * o)) & mask;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
    ld = v;
  endtask

  // Driver: starts and ends at a falling edge with the DUT idle.
  task automatic do_txn(input logic wren, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] st, input logic [31:0] rdata,
                        input int ack_delay, input bit no_ack);
    logic [1:0]  e_err;
    logic [3:0]  e_bm;
    logic [31:0] e_wd;
    logic [31:0] e_ld;
    int          e_req;
    int          req_cycles;
    int          budget;
    model(wren, f3, addr, st, rdata, e_err, e_bm, e_wd, e_ld);
    if (e_err != 2'b00) begin
      e_req  = 0;
      exp_ld = 32'd0;
    end else if (no_ack || ack_delay > T) begin
      e_err  = 2'b10;
      e_req  = T;
      exp_ld = 32'd0;
    end else begin
      e_req = ack_delay;
      if (!wren) exp_ld = e_ld;
    end
    i_lsu_req  = 1'b1;
    i_lsu_wren = wren;
    i_funct3   = f3;
    i_lsu_addr = addr;
    i_st_data  = st;
    #1;
    n_checks++;
    if (o_lsu_busy !== 1'b1) $display("FAIL busy_on_req: got %b want 1", o_lsu_busy);
    else n_pass++;
    @(negedge i_clk);
    i_lsu_req  = 1'b0;
    i_lsu_addr = $urandom;
    i_st_data  = $urandom;
    i_funct3   = 3'($urandom_range(0, 7));
    req_cycles = 0;
    budget     = 0;
    while (o_lsu_done !== 1'b1 && budget < 300) begin
      budget++;
      i_mem_ack   = 1'b0;
      i_mem_rdata = $urandom;
      if (o_mem_req === 1'b1) begin
        req_cycles++;
        n_checks++;
        if ({o_mem_wren, o_mem_addr, o_mem_bmask} !== {wren, addr[31:2], 2'b00, e_bm})
          $display("FAIL mem_cmd: got wren=%b addr=%h bmask=%b want wren=%b addr=%h bmask=%b",
                   o_mem_wren, o_mem_addr, o_mem_bmask, wren, {addr[31:2], 2'b00}, e_bm);
        else n_pass++;
        if (wren) begin
          n_checks++;
          if (o_mem_wdata !== e_wd) $display("FAIL mem_wdata: got %h want %h", o_mem_wdata, e_wd);
          else n_pass++;
        end
        if (!no_ack && req_cycles == ack_delay) begin
          i_mem_ack   = 1'b1;
          i_mem_rdata = rdata;
        end
      end
      n_checks++;
      if (o_lsu_busy !== 1'b1) $display("FAIL busy_in_access: got %b want 1", o_lsu_busy);
      else n_pass++;
      @(negedge i_clk);
    end
    i_mem_ack = 1'b0;
    n_checks++;
    if (o_lsu_done !== 1'b1) $display("FAIL done_pulse: got %b want 1", o_lsu_done);
    else n_pass++;
    n_checks++;
    if (req_cycles != e_req) $display("FAIL req_cycles: got %0d want %0d", req_cycles, e_req);
    else n_pass++;
    n_checks++;
    if (o_err_code !== e_err) $display("FAIL err_code: got %b want %b", o_err_code, e_err);
    else n_pass++;
    n_checks++;
    if (o_ld_data !== exp_ld) $display("FAIL ld_data: got %h want %h", o_ld_data, exp_ld);
    else n_pass++;
    n_checks++;
    if ({o_lsu_busy, o_mem_req} !== 2'b00)
      $display("FAIL busy_req_in_done: got %b want 00", {o_lsu_busy, o_mem_req});
    else n_pass++;
    @(negedge i_clk);
    n_checks++;
    if ({o_lsu_done, o_dbg_state} !== 3'b000)
      $display("FAIL back_to_idle: got done=%b state=%0d want done=0 state=0", o_lsu_done, o_dbg_state);
    else n_pass++;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    repeat (3) @(negedge i_clk);
    n_checks++;
    if ({o_mem_req, o_mem_wren, o_mem_addr, o_mem_wdata, o_mem_bmask, o_lsu_done,
         o_ld_data, o_err_code, o_lsu_busy, o_dbg_state} !== '0)
      $display("FAIL reset_outputs: got req=%b done=%b ld=%h err=%b busy=%b state=%0d want all 0",
               o_mem_req, o_lsu_done, o_ld_data, o_err_code, o_lsu_busy, o_dbg_state);
    else n_pass++;
    i_reset = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_store_word();
    do_txn(1'b1, 3'b010, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 2, 1'b0);
  endtask

  task automatic test_load_byte();
    do_txn(1'b0, 3'b000, 32'h0000_2003, 32'h0, 32'h8011_2233, 1, 1'b0);
    n_checks++;
    if (o_ld_data !== 32'hFFFF_FF80) $display("FAIL lb_sext: got %h want ffffff80", o_ld_data);
    else n_pass++;
    do_txn(1'b0, 3'b100, 32'h0000_2003, 32'h0, 32'h8011_2233, 1, 1'b0);
    n_checks++;
    if (o_ld_data !== 32'h0000_0080) $display("FAIL lbu_zext: got %h want 00000080", o_ld_data);
    else n_pass++;
  endtask

  task automatic test_half();
    do_txn(1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 32'h0, 1, 1'b0);
    n_checks++;
    if (o_ld_data !== 32'h0000_0080) $display("FAIL store_keeps_ld: got %h want 00000080", o_ld_data);
    else n_pass++;
    do_txn(1'b0, 3'b101, 32'h0000_3002, 32'h0, 32'hABCD_1234, 3, 1'b0);
    n_checks++;
    if (o_ld_data !== 32'h0000_ABCD) $display("FAIL lhu_zext: got %h want 0000abcd", o_ld_data);
    else n_pass++;
  endtask

  task automatic test_errors();
    do_txn(1'b0, 3'b010, 32'h0000_4001, 32'h0, 32'h0, 1, 1'b0);
    do_txn(1'b0, 3'b110, 32'h0000_4000, 32'h0, 32'h0, 1, 1'b0);
    do_txn(1'b1, 3'b101, 32'h0000_4000, 32'h0, 32'h0, 1, 1'b0);
    do_txn(1'b1, 3'b001, 32'h0000_4003, 32'h0, 32'h0, 1, 1'b0);
    do_txn(1'b1, 3'b011, 32'h0000_4000, 32'h0, 32'h0, 1, 1'b0);
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 3'b010, 32'h0000_7000, 32'h0, 32'h1234_5678, 4, 1'b0);
    do_txn(1'b0, 3'b010, 32'h0000_7004, 32'h0, 32'h0, 1, 1'b1);
    n_checks++;
    if (o_ld_data !== 32'h0) $display("FAIL timeout_clears_ld: got %h want 0", o_ld_data);
    else n_pass++;
  endtask

  task automatic test_done_ignores_req();
    i_lsu_req  = 1'b1;
    i_lsu_wren = 1'b0;
    i_funct3   = 3'b010;
    i_lsu_addr = 32'h0000_4002;
    @(negedge i_clk);
    i_lsu_addr = 32'h0000_6000;
    #1;
    n_checks++;
    if ({o_lsu_done, o_lsu_busy, o_err_code} !== 4'b1001)
      $display("FAIL done_with_req: got done=%b busy=%b err=%b want 1 0 01",
               o_lsu_done, o_lsu_busy, o_err_code);
    else n_pass++;
    @(negedge i_clk);
    n_checks++;
    if ({o_mem_req, o_dbg_state} !== 3'b000)
      $display("FAIL req_ignored_in_done: got req=%b state=%0d want 0 0", o_mem_req, o_dbg_state);
    else n_pass++;
    i_lsu_req = 1'b0;
    exp_ld    = 32'd0;
    @(negedge i_clk);
  endtask

  task automatic test_reset_mid_access();
    i_lsu_req  = 1'b1;
    i_lsu_wren = 1'b0;
    i_funct3   = 3'b010;
    i_lsu_addr = 32'h0000_5000;
    @(negedge i_clk);
    i_lsu_req = 1'b0;
    @(negedge i_clk);
    n_checks++;
    if (o_mem_req !== 1'b1) $display("FAIL req_before_reset: got %b want 1", o_mem_req);
    else n_pass++;
    i_reset = 1'b1;
    @(negedge i_clk);
    i_reset = 1'b0;
    exp_ld  = 32'd0;
    n_checks++;
    if ({o_mem_req, o_lsu_done, o_dbg_state, o_lsu_busy} !== 5'b0)
      $display("FAIL reset_in_access: got req=%b done=%b state=%0d busy=%b want all 0",
               o_mem_req, o_lsu_done, o_dbg_state, o_lsu_busy);
    else n_pass++;
    @(negedge i_clk);
    n_checks++;
    if ({o_mem_req, o_lsu_done} !== 2'b00)
      $display("FAIL no_done_after_reset: got req=%b done=%b want 0 0", o_mem_req, o_lsu_done);
    else n_pass++;
    do_txn(1'b0, 3'b010, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic [31:0] addr;
      addr = $urandom;
      do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom, $urandom,
             $urandom_range(1, T), ($urandom_range(0, 7) == 0));
    end
  endtask

  initial begin
    i_reset     = 1'b1;
    i_lsu_req   = 1'b0;
    i_lsu_wren  = 1'b0;
    i_funct3    = 3'b000;
    i_lsu_addr  = 32'd0;
    i_st_data   = 32'd0;
    i_mem_ack   = 1'b0;
    i_mem_rdata = 32'd0;
    @(negedge i_clk);
    test_reset();
    test_store_word();
    test_load_byte();
    test_half();
    test_errors();
    test_timeout();
    test_done_ignores_req();
    test_reset_mid_access();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
Load/store unit that sits directly downstream of the ALU. It takes the ALU result as the effective address and runs a byte-lane-aware request/acknowledge transaction with data memory. It sign- or zero-extends load data and stalls the pipeline while a transaction is outstanding. It also reports misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT_CYCLES, 255, maximum ACCESS-state cycles without i_mem_ack before abort (range 1..255; counter 8 bits).

Ports:
i_clk  in  1  clock, all state on rising edge
i_reset  in  1  synchronous, active-high reset
i_lsu_req  in  1  EX stage presents a load/store this cycle
i_lsu_wren  in  1  1=store, 0=load
i_funct3  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
i_lsu_addr  in  32  effective address (ALU o_alu_data)
i_st_data  in  32  store data (rs2)
o_lsu_busy  out  1  pipeline stall request
o_lsu_done  out  1  one-cycle completion pulse
o_ld_data  out  32  formatted load result
o_err_code  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3; valid with o_lsu_done
o_mem_req  out  1  memory request, held until ack
o_mem_wren  out  1  memory write enable
o_mem_addr  out  32  word address {addr[31:2],2'b00}
o_mem_wdata  out  32  lane-replicated store data
o_mem_bmask  out  4  byte-lane enables
i_mem_ack  in  1  memory accepted write / rdata valid this cycle
i_mem_rdata  in  32  memory read word

Behaviour:
- Single clock; reset is synchronous and active-high. While i_reset=1 at an edge: state=IDLE, timeout counter=0, all outputs 0 (o_ld_data=0, o_err_code=00). A reset during ACCESS drops o_mem_req on the same edge and produces no done pulse.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, i_lsu_req=1, access legal: latch address offset, funct3 and wren. Drive the registered memory outputs. Go to ACCESS.
- IDLE, access illegal: no memory request. Go to DONE with the error code.
  - Misaligned: H/HU/SH with addr[0]=1; W/SW with addr[1:0]!=00.
  - Illegal: funct3 in {011,110,111}; 100/101 with wren=1.
- ACCESS: o_mem_req=1. Addr/wdata/bmask/wren stay stable. Counter increments each cycle.
  - i_mem_ack=1 → DONE, err=00. Loads capture formatted rdata into o_ld_data on that edge.
  - Counter reaches TIMEOUT_CYCLES-1 without ack → DONE, err=10, o_ld_data=0.
  - o_mem_req deasserts on the transition edge.
- DONE: o_lsu_done=1 for exactly one cycle, then IDLE. i_lsu_req is ignored in DONE.
- o_lsu_busy (combinational) = (IDLE & i_lsu_req) | ACCESS; it is 0 in DONE so the pipeline advances on the done cycle.
- Lane rules, o = addr[1:0]:
  - B: bmask=1<<o, wdata={4{st[7:0]}}.
  - H: bmask = o[1] ? 1100 : 0011, wdata={2{st[15:0]}}.
  - W: bmask=1111, wdata=st.
  - Loads drive the same bmask with wren=0.
- Load format: select byte rdata[8o+7:8o] or half rdata[16o[1]+15:16o[1]]. Sign-extend for B/H, zero-extend for BU/HU.
- o_ld_data updates only on successful load completion or is cleared to 0 on error; stores leave it unchanged.
- Minimum latency: req at cycle 0, ack at cycle 1, done at cycle 2.

Test Plan:
- SW addr=0x1004, st=0xDEADBEEF, ack 2 cycles after req → mem_addr 0x1004, bmask 1111, wdata 0xDEADBEEF, wren=1; done with err 00; busy high until the done cycle.
- LB addr=0x2003, rdata=0x80112233, immediate ack → bmask 1000, o_ld_data=0xFFFFFF80; LBU at the same address → 0x00000080.
- SH addr=0x3002, st=0x0000ABCD → bmask 1100, wdata 0xABCDABCD; LHU addr=0x3002, rdata=0xABCD1234 → 0x0000ABCD.
- LW addr=0x4001 → no o_mem_req, done next cycle with err 01; funct3=110 → err 11.
- LW with no ack, TIMEOUT_CYCLES=4 → o_mem_req high exactly 4 cycles, then done with err 10, o_ld_data=0.
- Reset asserted on the 2nd ACCESS cycle → o_mem_req=0 and state IDLE next cycle, no done; a fresh LW then completes normally.
